// File: rtl/fixed_relu_pipe.sv
// fixed_relu_pipe: two-stage ReLU-family activation with precision
// conversion, round-half-up, saturation, framing and sticky sat flag.
module fixed_relu_pipe #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int LEAKY_SHIFT                 = 3,
  parameter int CLIP_INT                    = 6,
  localparam int P = DATA_IN_0_PARALLELISM_DIM_0
                   * DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          act_mode,
  input  logic [P*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                data_in_0_valid,
  output logic                                data_in_0_ready,
  output logic [P*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                data_out_0_valid,
  input  logic                                data_out_0_ready,
  output logic                                data_out_0_last,
  output logic                                sat_flag
);

  localparam int IW = DATA_IN_0_PRECISION_0;
  localparam int IF = DATA_IN_0_PRECISION_1;
  localparam int OW = DATA_OUT_0_PRECISION_0;
  localparam int OF = DATA_OUT_0_PRECISION_1;

  localparam int BEATS =
    (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0)
    * (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  localparam int D  = OF - IF;
  localparam int SL = (D > 0) ? D : 0;
  localparam int SR = (D < 0) ? -D : 0;
  // Two guard bits cover the rounding add and the sign.
  localparam int WA = IW + SL + 2;
  localparam int WW = (WA > OW + 1) ? WA : OW + 1;

  localparam longint OMAX_L = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN_L = -(longint'(1) <<< (OW - 1));
  localparam longint THR_L  = longint'(CLIP_INT) <<< OF;
  localparam longint THR_C  = (THR_L > OMAX_L) ? OMAX_L : THR_L;

  localparam logic signed [WW-1:0] RND    = WW'((longint'(1) <<< SR) >>> 1);
  localparam logic signed [WW-1:0] OMAX_W = WW'(OMAX_L);
  localparam logic signed [WW-1:0] OMIN_W = WW'(OMIN_L);
  localparam logic signed [WW-1:0] THR_W  = WW'(THR_C);

  function automatic logic [OW:0] act_elem(
    input logic [IW-1:0] x_raw,
    input logic [1:0]    m
  );
    logic signed [WW-1:0] x;
    logic signed [WW-1:0] a;
    logic signed [WW-1:0] r;
    logic signed [WW-1:0] y;
    logic                 s;
    x = WW'($signed(x_raw));
    a = x;
    unique case (1'b1)
      (m == 2'd0), (m == 2'd2): a = (x > 0) ? x : '0;
      (m == 2'd1): a = (x < 0) ? (x >>> LEAKY_SHIFT) : x;
      default: a = x;
    endcase
    if (D >= 0) r = a <<< SL;
    else        r = (a + RND) >>> SR;
    s = 1'b0;
    y = r;
    if (r > OMAX_W) begin
      y = OMAX_W;
      s = 1'b1;
    end else if (r < OMIN_W) begin
      y = OMIN_W;
      s = 1'b1;
    end
    // The clip ceiling is a mode feature, not an overflow.
    if (m == 2'd2 && y > THR_W) y = THR_W;
    return {s, y[OW-1:0]};
  endfunction

  logic [P*OW-1:0] nxt_data;
  logic [P-1:0]    nxt_sat;

  always_comb begin
    nxt_data = '0;
    nxt_sat  = '0;
    for (int i = 0; i < P; i++) begin
      {nxt_sat[i], nxt_data[i*OW +: OW]} =
        act_elem(data_in_0[i*IW +: IW], act_mode);
    end
  end

  logic            s1_valid;
  logic [P*OW-1:0] s1_data;
  logic            s1_last;
  logic            s1_sat;
  logic            s1_ready;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  assign s1_ready        = !data_out_0_valid || data_out_0_ready;
  assign data_in_0_ready = !s1_valid || s1_ready;
  assign cnt_last        = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s1_sat   <= 1'b0;
      cnt      <= '0;
    end else if (data_in_0_ready) begin
      s1_valid <= data_in_0_valid;
      if (data_in_0_valid) begin
        s1_data <= nxt_data;
        s1_last <= cnt_last;
        s1_sat  <= |nxt_sat;
        cnt     <= cnt_last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_0_valid <= 1'b0;
      data_out_0       <= '0;
      data_out_0_last  <= 1'b0;
      sat_flag         <= 1'b0;
    end else if (s1_ready) begin
      data_out_0_valid <= s1_valid;
      if (s1_valid) begin
        data_out_0      <= s1_data;
        data_out_0_last <= s1_last;
        if (s1_sat) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_relu_pipe.sv
// tb_fixed_relu_pipe: directed and random beats through fixed_relu_pipe
// (12.5 in, 8.3 out, P=2, 4 beats per tensor) against an arithmetic model.
module tb_fixed_relu_pipe;

  localparam int IW = 12;
  localparam int OW = 8;
  localparam int P  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      act_mode;
  logic [P*IW-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [P*OW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic            sat_flag;

  always #5 clk = ~clk;

  fixed_relu_pipe #(
    .DATA_IN_0_PRECISION_0      (12),
    .DATA_IN_0_PRECISION_1      (5),
    .DATA_OUT_0_PRECISION_0     (8),
    .DATA_OUT_0_PRECISION_1     (3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(8),
    .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(2),
    .DATA_IN_0_PARALLELISM_DIM_1(1),
    .LEAKY_SHIFT                (2),
    .CLIP_INT                   (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .act_mode        (act_mode),
    .data_in_0       (din),
    .data_in_0_valid (din_valid),
    .data_in_0_ready (din_ready),
    .data_out_0      (dout),
    .data_out_0_valid(dout_valid),
    .data_out_0_ready(dout_ready),
    .data_out_0_last (dout_last),
    .sat_flag        (sat_flag)
  );

  typedef struct {
    logic [P*IW-1:0] d;
    logic [1:0]      m;
  } stim_t;

  typedef struct {
    logic [P*OW-1:0] d;
    logic            l;
    bit              s;
  } exp_t;

  stim_t stim[$];
  exp_t  expq[$];
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;
  int    beat_cnt = 0;
  bit    sat_cum = 0;
  int    cyc = 0;
  int    stall_lo = 1;
  int    stall_hi = 0;
  bit    acc_prev = 0;
  bit    saw_block = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Real-valued rules: input step 1/32, output step 1/8, slope 1/4,
  // ceiling 6.0 = 48 output LSBs, range [-128, 127].
  function automatic void ref_elem(input int x, input logic [1:0] m,
                                   output int y, output bit s);
    int a;
    int r;
    case (m)
      2'd0, 2'd2: a = (x > 0) ? x : 0;
      2'd1:       a = (x < 0) ? fdiv(x, 4) : x;
      default:    a = x;
    endcase
    r = fdiv(a + 2, 4);
    s = (r > 127) || (r < -128);
    y = (r > 127) ? 127 : ((r < -128) ? -128 : r);
    if (m == 2'd2 && y > 48) y = 48;
  endfunction

  task automatic accept_model(input stim_t st);
    exp_t e;
    int   x;
    int   y;
    bit   es;
    bit   bs;
    bs = 0;
    e.d = '0;
    for (int i = 0; i < P; i++) begin
      x = int'($signed(st.d[i*IW +: IW]));
      ref_elem(x, st.m, y, es);
      e.d[i*OW +: OW] = y[OW-1:0];
      bs = bs | es;
    end
    e.l = (beat_cnt == 3);
    beat_cnt = (beat_cnt + 1) % 4;
    sat_cum = sat_cum | bs;
    e.s = sat_cum;
    expq.push_back(e);
  endtask

  task automatic add(input int x0, input int x1, input logic [1:0] m);
    stim_t s;
    s.d = {x1[IW-1:0], x0[IW-1:0]};
    s.m = m;
    stim.push_back(s);
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) begin
      add(int'($urandom_range(0, 4095)) - 2048,
          int'($urandom_range(0, 4095)) - 2048,
          2'($urandom_range(0, 3)));
    end
  endtask

  task automatic run(input int budget, input bit drain);
    for (int k = 0; k < budget; k++) begin
      if (drain && stim.size() == 0 && !din_valid && expq.size() == 0)
        break;
      @(negedge clk);
      dout_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (acc_prev) begin
        din_valid = 1'b0;
        acc_prev = 0;
      end
      if (!din_valid && stim.size() > 0) begin
        din = stim[0].d;
        act_mode = stim[0].m;
        din_valid = 1'b1;
      end
      #1;
      check("in_ready", din_ready, !(expq.size() == 2 && !dout_ready));
      if (din_valid && !din_ready) saw_block = 1;
      if (expq.size() == 0) begin
        check("spurious_valid", dout_valid, 1'b0);
      end else if (dout_valid) begin
        check("out_data", dout, expq[0].d);
        check("out_last", dout_last, expq[0].l);
        if (expq[0].s) check("sat_set", sat_flag, 1'b1);
        if (dout_ready) void'(expq.pop_front());
      end
      if (din_valid && din_ready) begin
        accept_model(stim.pop_front());
        acc_prev = 1;
      end
      cyc = cyc + 1;
    end
    if (drain) begin
      check("drain", stim.size() + expq.size(), 0);
      check("sat_final", sat_flag, sat_cum);
    end
  endtask

  initial begin
    stim_t s0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    act_mode = 2'd0;
    dout_ready = 1'b0;
    #1;
    check("rst_valid", dout_valid, 1'b0);
    check("rst_last", dout_last, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_data", dout, 16'h0000);
    check("rst_in_ready", din_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Latency: one beat, output register loads on the second edge.
    @(negedge clk);
    s0.d = {12'd28, 12'd28};
    s0.m = 2'd0;
    din = s0.d;
    act_mode = s0.m;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    accept_model(s0);
    check("lat_edge1_valid", dout_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", dout_valid, 1'b1);
    check("lat_data", dout, expq[0].d);
    check("lat_data_const", dout, 16'h0707);
    check("lat_last", dout_last, expq[0].l);
    void'(expq.pop_front());
    @(posedge clk);
    #1;
    check("lat_gone", dout_valid, 1'b0);

    // Non-saturating directed beats across all modes.
    add(-40, 0, 2'd0);
    add(0, 28, 2'd0);
    add(-32, -5, 2'd1);
    add(12, -20, 2'd1);
    add(-6, 6, 2'd3);
    add(400, 80, 2'd2);
    add(-8, -100, 2'd2);
    cyc = 0;
    run(100, 1);
    check("no_sat_yet", sat_flag, 1'b0);

    // Backpressure: output stalled for cycles 3..7.
    stall_lo = 3;
    stall_hi = 7;
    cyc = 0;
    saw_block = 0;
    for (int i = 0; i < 8; i++) add(16 * i - 40, 8 * i, 2'(i % 4));
    run(100, 1);
    check("ready_dropped", saw_block, 1'b1);

    // Saturation, then sticky across small values.
    stall_lo = 1;
    stall_hi = 0;
    cyc = 0;
    add(2047, 100, 2'd0);
    add(10, 10, 2'd0);
    add(-2048, 5, 2'd3);
    add(3, -3, 2'd1);
    run(100, 1);
    check("sat_sticky", sat_flag, 1'b1);

    // Random beats and modes with a stall window.
    stall_lo = 10;
    stall_hi = 25;
    cyc = 0;
    add_rand(40);
    run(400, 1);

    // Reset with a full pipe.
    stall_lo = 0;
    stall_hi = 100000;
    cyc = 0;
    add_rand(3);
    run(6, 0);
    check("full_before_rst", expq.size(), 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", dout_valid, 1'b0);
    check("mid_rst_last", dout_last, 1'b0);
    check("mid_rst_sat", sat_flag, 1'b0);
    check("mid_rst_in_ready", din_ready, 1'b1);
    stim.delete();
    expq.delete();
    din_valid = 1'b0;
    acc_prev = 0;
    beat_cnt = 0;
    sat_cum = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stall_lo = 1;
    stall_hi = 0;
    cyc = 0;
    add(8, 8, 2'd0);
    add(16, -16, 2'd1);
    add(24, 100, 2'd3);
    add(400, -1, 2'd2);
    run(50, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
